stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Two-digit BCD stopwatch controller. It turns three raw push-button inputs into start/stop, lap and clear commands, sequences a prescaler and a ones/tens BCD counter through a four-state FSM, and drives the display digits either live or frozen at a lap value. It sits between the board buttons and the 7-segment decoders, replacing free-running counters in the timing demos.

## Interface
- DIV, 25'd4: prescaler terminal count; one count tick every DIV cycles while counting; legal 2..2^25-1.
- DEB_LEN, 16: debounce length, in consecutive stable-high cycles; legal 1..65535.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-low.
- btn_start_stop  in  1  raw button, active-high, asynchronous to clk.
- btn_lap  in  1  raw button, active-high, asynchronous.
- btn_clear  in  1  raw button, active-high, asynchronous.
- ones  out  4  displayed BCD units digit, 0..9.
- tens  out  4  displayed BCD tens digit, 0..9.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP; the display shows the frozen value.
- overflow  out  1  one-cycle pulse when the count wraps from 99 to 00.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer emits a one-cycle press pulse on the DEB_LEN-th consecutive high cycle of the synchronized level.
  - No further pulse is emitted until the level has been seen low for at least one cycle.
- Command priority for same-cycle pulses: clear > start_stop > lap. Lower-priority pulses in that cycle are dropped.
- FSM states and transitions (no other transitions exist):
  - IDLE: start_stop -> RUN. Clear stays in IDLE.
  - RUN: start_stop -> PAUSE. Lap -> LAP and captures the live count into the lap register. Clear is ignored.
  - LAP: lap -> RUN (display goes live). Start_stop -> PAUSE (display goes live, lap register is kept). Clear is ignored.
  - PAUSE: start_stop -> RUN. Clear -> IDLE and zeroes the prescaler and both digits.
- Prescaler:
  - Counts only in RUN and LAP; holds its value in PAUSE; forced to 0 in IDLE.
  - Tick when prescaler == DIV-1, in the same cycle it reloads to 0.
- BCD counter, advanced on each tick:
  - ones 9 -> 0 with a carry to tens; otherwise ones+1.
  - tens 9 -> 0 on a carry.
  - 99 -> 00 raises overflow in the cycle the digits become 00.
  - Digits are never outside 0..9.
- Display: ones/tens show the lap register in LAP and the live count in every other state.

## Timing
- Reset values: FSM = IDLE, prescaler 0, live and lap digits 0, ones=0, tens=0, running=0, lap_active=0, overflow=0, debouncer counters 0.
- Reset asserted mid-count returns everything to the reset values immediately, with no clock needed.
- Button to state latency: press pulse at cycle 2+DEB_LEN after the first sampled high; the FSM updates on the next edge.
- All outputs are registered. running and lap_active change on the same edge as the FSM.
- First tick after IDLE -> RUN comes DIV cycles after entering RUN.
- After PAUSE -> RUN, the prescaler resumes from its held value, so no partial period is lost.
- A tick and a start_stop pulse in the same cycle in RUN: the tick is applied, and the state becomes PAUSE.
- Counting continues unchanged in LAP; the LAP -> RUN display switch is glitch-free on one edge.

## Structure
- Package stopwatch_pkg holds:
  - state enum (IDLE, RUN, PAUSE, LAP), 2 bits;
  - BCD_MAX = 4'd9;
  - the command priority encoding.
- Sub-module btn_debounce (synchronizer + stable counter + press pulse), parameter DEB_LEN, instantiated three times.
- The FSM, prescaler, BCD counter, lap register and display mux live in stopwatch_ctrl.

## Test plan
Bench uses DIV=4, DEB_LEN=3.
- Reset then idle for 20 cycles -> ones=0, tens=0, running=0, overflow never high.
- Start press, run 40 cycles after the RUN edge -> count 10 (ones=0, tens=1); tick period exactly 4 cycles.
- Run to 99, then one more tick -> 00 with a single-cycle overflow; tens carries correctly at 09 -> 10 and 19 -> 20.
- In RUN at 12, press lap -> display frozen at 12, lap_active=1. After 8 cycles press lap -> display shows the live value 14; running stays 1 throughout.
- Pause at 07 after 2 prescaler cycles, hold 50 cycles -> display 07. Resume -> next tick 2 cycles after the RUN edge. Clear in PAUSE -> IDLE, display 00.
- Clear, start_stop and lap pressed on the same edge in RUN -> only start_stop acts, giving PAUSE. A 2-cycle glitch pulse on btn_lap -> no state change. Reset asserted mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the two-digit BCD stopwatch:
//                FSM state encoding, BCD limit and button command priority.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   // Controller states; 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_e;

   // Largest legal BCD digit value.
   localparam logic [3:0] BCD_MAX = 4'd9;

   // One command per cycle after priority resolution.
   typedef enum logic [1:0] {
      CMD_NONE       = 2'd0,
      CMD_CLEAR      = 2'd1,
      CMD_START_STOP = 2'd2,
      CMD_LAP        = 2'd3
   } sw_cmd_e;

   // Priority: clear > start_stop > lap; lower-priority pulses are dropped.
   function automatic sw_cmd_e encode_cmd(input logic clear,
                                          input logic start_stop,
                                          input logic lap);
      sw_cmd_e cmd;
      if (clear)           cmd = CMD_CLEAR;
      else if (start_stop) cmd = CMD_START_STOP;
      else if (lap)        cmd = CMD_LAP;
      else                 cmd = CMD_NONE;
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-flop synchronizer plus stable-high counter. Emits a single
//                registered press pulse on the DEB_LEN-th consecutive high
//                cycle of the synchronized level; re-arms only after the
//                level has been seen low.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEB_LEN = 16
) (
   input  logic clk,
   input  logic rst,      // asynchronous, active-low
   input  logic btn,      // raw button, asynchronous to clk
   output logic press     // one-cycle press pulse
);

   localparam int unsigned CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_LEN);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   // Stable-high counter saturates at DEB_LEN, which also blocks repeat pulses
   // until the level drops and the counter is cleared.
   always_comb begin
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (!sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_MAX - CNT_W'(1)) begin
            press_d = 1'b1;
         end
      end
   end

   // Synchronizer, counter and pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Two-digit BCD stopwatch controller. Debounced buttons drive
//                an IDLE/RUN/PAUSE/LAP FSM that sequences a prescaler, a
//                ones/tens BCD counter, a lap register and the display mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter logic [24:0] DIV     = 25'd4,
   parameter int unsigned DEB_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,             // asynchronous, active-low
   input  logic       btn_start_stop,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   logic press_start_stop, press_lap, press_clear;

   btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_start_stop (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_start_stop),
      .press (press_start_stop)
   );

   btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_lap (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_lap),
      .press (press_lap)
   );

   btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_clear (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_clear),
      .press (press_clear)
   );

   sw_state_e   state_q, state_d;
   logic [24:0] presc_q, presc_d;
   logic [3:0]  live_ones_q, live_ones_d, live_tens_q, live_tens_d;
   logic [3:0]  lap_ones_q, lap_ones_d, lap_tens_q, lap_tens_d;
   logic [3:0]  ones_q, ones_d, tens_q, tens_d;
   logic        running_q, running_d;
   logic        lap_active_q, lap_active_d;
   logic        overflow_q, overflow_d;

   logic        clear_valid;
   sw_cmd_e     cmd;
   logic        counting;
   logic        tick;
   logic        do_clear;

   // Clear only takes part in arbitration where it has an effect (IDLE/PAUSE),
   // so a clear held with start_stop in RUN does not mask the start_stop.
   always_comb begin
      clear_valid = press_clear && ((state_q == ST_PAUSE) || (state_q == ST_IDLE));
      cmd         = encode_cmd(clear_valid, press_start_stop, press_lap);
      state_d     = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd == CMD_START_STOP) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cmd == CMD_START_STOP)   state_d = ST_PAUSE;
            else if (cmd == CMD_LAP)     state_d = ST_LAP;
         end
         ST_LAP: begin
            if (cmd == CMD_LAP)               state_d = ST_RUN;
            else if (cmd == CMD_START_STOP)   state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (cmd == CMD_START_STOP)   state_d = ST_RUN;
            else if (cmd == CMD_CLEAR)   state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Prescaler, BCD counter and lap capture; the tick is applied even in the
   // cycle the FSM leaves RUN/LAP so no counted period is lost.
   always_comb begin
      counting    = (state_q == ST_RUN) || (state_q == ST_LAP);
      tick        = counting && (presc_q == DIV - 25'd1);
      do_clear    = (state_q == ST_PAUSE) && (cmd == CMD_CLEAR);
      presc_d     = presc_q;
      live_ones_d = live_ones_q;
      live_tens_d = live_tens_q;
      lap_ones_d  = lap_ones_q;
      lap_tens_d  = lap_tens_q;
      overflow_d  = 1'b0;

      if (state_q == ST_IDLE || do_clear) begin
         presc_d = '0;
      end else if (counting) begin
         presc_d = tick ? 25'd0 : presc_q + 25'd1;
      end

      if (do_clear) begin
         live_ones_d = '0;
         live_tens_d = '0;
      end else if (tick) begin
         if (live_ones_q >= BCD_MAX) begin
            live_ones_d = '0;
            if (live_tens_q >= BCD_MAX) begin
               live_tens_d = '0;
               overflow_d  = 1'b1;
            end else begin
               live_tens_d = live_tens_q + 4'd1;
            end
         end else begin
            live_ones_d = live_ones_q + 4'd1;
         end
      end

      if (state_q == ST_RUN && cmd == CMD_LAP) begin
         lap_ones_d = live_ones_q;
         lap_tens_d = live_tens_q;
      end
   end

   // Registered outputs are computed from next-state values so they switch
   // on the same edge as the FSM.
   always_comb begin
      running_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_active_d = (state_d == ST_LAP);
      if (state_d == ST_LAP) begin
         ones_d = lap_ones_d;
         tens_d = lap_tens_d;
      end else begin
         ones_d = live_ones_d;
         tens_d = live_tens_d;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         presc_q      <= '0;
         live_ones_q  <= '0;
         live_tens_q  <= '0;
         lap_ones_q   <= '0;
         lap_tens_q   <= '0;
         ones_q       <= '0;
         tens_q       <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         live_ones_q  <= live_ones_d;
         live_tens_q  <= live_tens_d;
         lap_ones_q   <= lap_ones_d;
         lap_tens_q   <= lap_tens_d;
         ones_q       <= ones_d;
         tens_q       <= tens_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
         overflow_q   <= overflow_d;
      end
   end

   assign ones       = ones_q;
   assign tens       = tens_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed self-checking bench for stopwatch_ctrl with
//                DIV=4, DEB_LEN=3. A press driven just after edge D is
//                pulsed after edge D+5 and changes the FSM at edge D+6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start_stop = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clear = 1'b0;
   logic [3:0] ones, tens;
   logic       running, lap_active, overflow;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(.DIV(25'd4), .DEB_LEN(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_start_stop (btn_start_stop),
      .btn_lap        (btn_lap),
      .btn_clear      (btn_clear),
      .ones           (ones),
      .tens           (tens),
      .running        (running),
      .lap_active     (lap_active),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the chosen buttons for 4 edges, release, and advance to 1 unit
   // after the edge where the FSM acts on the press.
   task automatic press(input logic s, input logic l, input logic c);
      btn_start_stop = s;
      btn_lap        = l;
      btn_clear      = c;
      step(4);
      btn_start_stop = 1'b0;
      btn_lap        = 1'b0;
      btn_clear      = 1'b0;
      step(2);
   endtask

   function automatic logic [7:0] disp();
      return {tens, ones};
   endfunction

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #1 rst = 1'b0;
      #2;
      check("rst_disp", disp(), 8'h00);
      check("rst_running", running, 1'b0);
      check("rst_lap_active", lap_active, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      step(2);
      rst = 1'b1;

      // Idle for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("idle_overflow", overflow, 1'b0);
      end
      check("idle_disp", disp(), 8'h00);
      check("idle_running", running, 1'b0);

      // Start; E = RUN edge.
      press(1'b1, 1'b0, 1'b0);
      check("run_running", running, 1'b1);
      check("run_lap_active", lap_active, 1'b0);
      check("run_disp_e0", disp(), 8'h00);
      step(3);  check("run_e3", disp(), 8'h00);
      step(1);  check("run_e4", disp(), 8'h01);
      step(3);  check("run_e7", disp(), 8'h01);
      step(1);  check("run_e8", disp(), 8'h02);
      step(28); check("run_09", disp(), 8'h09);
      step(4);  check("run_10", disp(), 8'h10);
      step(36); check("run_19", disp(), 8'h19);
      step(4);  check("run_20", disp(), 8'h20);
      step(316); check("run_99", disp(), 8'h99);
      check("run_99_ovf", overflow, 1'b0);
      step(3);  check("run_99_hold", disp(), 8'h99);
      step(1);  check("wrap_00", disp(), 8'h00);
      check("wrap_ovf", overflow, 1'b1);
      step(1);  check("wrap_ovf_clr", overflow, 1'b0);
      check("wrap_disp", disp(), 8'h00);

      // Live count restarted at 00 with prescaler 0 (E'); 12 at E'+48.
      step(43);
      press(1'b0, 1'b1, 1'b0);            // LAP at E'+50
      check("lap_active", lap_active, 1'b1);
      check("lap_running", running, 1'b1);
      check("lap_disp", disp(), 8'h12);
      step(2);
      btn_lap = 1'b1;
      step(4);                            // E'+56, live is 14
      check("lap_frozen", disp(), 8'h12);
      check("lap_running2", running, 1'b1);
      btn_lap = 1'b0;
      step(2);                            // RUN at E'+58
      check("unlap_active", lap_active, 1'b0);
      check("unlap_running", running, 1'b1);
      check("unlap_disp", disp(), 8'h14);

      // Pause on the same edge as a tick (E'+64): tick applied, 16 shown.
      press(1'b1, 1'b0, 1'b0);
      check("pause_tick_running", running, 1'b0);
      check("pause_tick_disp", disp(), 8'h16);
      step(10); check("pause_hold16", disp(), 8'h16);
      press(1'b0, 1'b0, 1'b1);
      check("clear_disp", disp(), 8'h00);
      check("clear_running", running, 1'b0);
      step(8);  check("clear_idle", disp(), 8'h00);

      // Pause at 07 with prescaler at 2, then resume.
      press(1'b1, 1'b0, 1'b0);            // RUN at E2
      step(24);
      press(1'b1, 1'b0, 1'b0);            // PAUSE at E2+30
      check("pause07_running", running, 1'b0);
      check("pause07_disp", disp(), 8'h07);
      step(50);
      check("pause07_hold", disp(), 8'h07);
      press(1'b1, 1'b0, 1'b0);            // RUN at R
      check("resume_running", running, 1'b1);
      step(1);  check("resume_r1", disp(), 8'h07);
      step(1);  check("resume_r2", disp(), 8'h08);
      press(1'b1, 1'b0, 1'b0);            // PAUSE at R+8
      check("pause09_disp", disp(), 8'h09);
      press(1'b0, 1'b0, 1'b1);            // IDLE
      check("clear2_disp", disp(), 8'h00);
      check("clear2_running", running, 1'b0);

      // All three buttons together in RUN: start_stop wins -> PAUSE.
      press(1'b1, 1'b0, 1'b0);            // RUN at E3
      check("e3_running", running, 1'b1);
      press(1'b1, 1'b1, 1'b1);            // PAUSE at E3+6
      check("multi_running", running, 1'b0);
      check("multi_lap_active", lap_active, 1'b0);
      check("multi_disp", disp(), 8'h01);

      // Resume, then a 2-cycle lap glitch must be filtered.
      press(1'b1, 1'b0, 1'b0);            // RUN at R3
      btn_lap = 1'b1;
      step(2);
      btn_lap = 1'b0;
      step(6);                            // R3+8
      check("glitch_lap_active", lap_active, 1'b0);
      check("glitch_running", running, 1'b1);
      check("glitch_disp", disp(), 8'h03);

      // Asynchronous reset mid-count.
      #3 rst = 1'b0;
      #1;
      check("arst_disp", disp(), 8'h00);
      check("arst_running", running, 1'b0);
      check("arst_lap_active", lap_active, 1'b0);
      check("arst_overflow", overflow, 1'b0);
      #2 rst = 1'b1;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
